apu_envelope_bank: RTL and testbench

Parametrised bank of APU volume-envelope generators, one per channel (default: pulse 1, pulse 2, noise). Each channel holds its loop/constant/period settings and a start flag, and runs a programmable divider clocked by the frame sequencer's quarter-frame tick. Each channel produces either a constant volume or a decaying sawtooth level. The bank sits between the APU register-write decode and the per-channel DAC mixers. It replaces single-channel envelopes that have no divider.

---
 rtl/apu_envelope_bank_if.sv | 37 +++
 rtl/apu_envelope_bank.sv | 89 ++++++++
 tb/tb_apu_envelope_bank.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/apu_envelope_bank_if.sv
// apu_envelope_bank_if
//   Register-write side and mixer side of the APU envelope bank.
//   N channels, each W bits wide.
//
//   Handshake semantics:
//     set, restart and qframe are single-cycle strobes. They are sampled on
//     every rising m_clock edge. There is no back-pressure and no ready
//     signal: a strobe that is high at an edge is always consumed on that
//     edge. l, d and n only need to be valid in a cycle where some set bit
//     is high.
//
//   Signals:
//     set     [N]   per-channel register-write strobe (latches l, d, n)
//     l             loop flag (also the length-counter halt bit)
//     d             constant-volume flag
//     n       [W]   period / constant volume
//     restart [N]   per-channel start-flag strobe
//     qframe        quarter-frame tick from the frame sequencer
//     Vo      [N*W] packed channel volumes, channel k at [k*W +: W]
//
//   Modports: master = register decode / frame sequencer side,
//             slave  = envelope bank.
interface apu_envelope_bank_if #(
   parameter int N = 3,
   parameter int W = 4
);
   logic [N-1:0]   set;
   logic           l;
   logic           d;
   logic [W-1:0]   n;
   logic [N-1:0]   restart;
   logic           qframe;
   logic [N*W-1:0] Vo;

   modport master (output set, l, d, n, restart, qframe, input Vo);
   modport slave  (input set, l, d, n, restart, qframe, output Vo);
endinterface

// File: rtl/apu_envelope_bank.sv
// apu_envelope_bank
//   Bank of N APU volume-envelope generators. Each channel has a
//   programmable divider that is clocked by the quarter-frame tick. Each
//   channel outputs either a constant volume (d_r=1) or a decaying sawtooth
//   that can optionally loop.
//
//   Ports:
//     m_clock  system clock; all state changes on its rising edge
//     p_reset  asynchronous active-high reset; clears every register
//     bus      apu_envelope_bank_if.slave (register writes, qframe, Vo)
module apu_envelope_bank #(
   parameter int N = 3,
   parameter int W = 4
) (
   input  logic               m_clock,
   input  logic               p_reset,
   apu_envelope_bank_if.slave bus
);

   localparam logic [W-1:0] DECAY_MAX = {W{1'b1}};
   localparam logic [W-1:0] ONE       = W'(1);

   logic [W-1:0]   vo_ch [N];
   logic [N*W-1:0] vo_pack;

   for (genvar k = 0; k < N; k++) begin : g_ch
      logic         l_r;
      logic         d_r;
      logic [W-1:0] n_r;
      logic         start;
      logic [W-1:0] div;
      logic [W-1:0] decay;

      always_ff @(posedge m_clock or posedge p_reset) begin
         if (p_reset) begin
            l_r   <= 1'b0;
            d_r   <= 1'b0;
            n_r   <= '0;
            start <= 1'b0;
            div   <= '0;
            decay <= '0;
         end else begin
            // The tick below reads the pre-edge n_r and l_r. A write in
            // the same cycle therefore only affects later ticks.
            if (bus.set[k]) begin
               l_r <= bus.l;
               d_r <= bus.d;
               n_r <= bus.n;
            end

            if (bus.qframe) begin
               if (start) begin
                  decay <= DECAY_MAX;
                  div   <= n_r;
               end else if (div == '0) begin
                  div <= n_r;
                  if (decay != '0) begin
                     decay <= decay - ONE;
                  end else if (l_r) begin
                     decay <= DECAY_MAX;
                  end
               end else begin
                  div <= div - ONE;
               end
            end

            // A restart that lands on a tick wins over the tick's clear.
            // The restart is then serviced on the following tick.
            if (bus.restart[k]) begin
               start <= 1'b1;
            end else if (bus.qframe && start) begin
               start <= 1'b0;
            end
         end
      end

      assign vo_ch[k] = d_r ? n_r : decay;
   end

   always_comb begin
      vo_pack = '0;
      for (int k = 0; k < N; k++) begin
         vo_pack[k*W +: W] = vo_ch[k];
      end
   end

   assign bus.Vo = vo_pack;

endmodule

// File: tb/tb_apu_envelope_bank.sv
// tb_apu_envelope_bank
//   Self-checking bench for apu_envelope_bank.
//   Directed scenarios are checked with closed-form expectations. Random
//   traffic is checked against a per-channel reference model of levels and
//   tick countdowns. A second instance with N=4, W=5 covers the parameters.
module tb_apu_envelope_bank;

   localparam int N    = 3;
   localparam int W    = 4;
   localparam int MAXV = (1 << W) - 1;

   logic m_clock = 1'b0;
   logic p_reset;

   always #5 m_clock = ~m_clock;

   apu_envelope_bank_if #(.N(N), .W(W)) bus ();
   apu_envelope_bank #(.N(N), .W(W)) dut (
      .m_clock (m_clock),
      .p_reset (p_reset),
      .bus     (bus)
   );

   apu_envelope_bank_if #(.N(4), .W(5)) bus5 ();
   apu_envelope_bank #(.N(4), .W(5)) dut5 (
      .m_clock (m_clock),
      .p_reset (p_reset),
      .bus     (bus5)
   );

   int errors = 0;
   int checks = 0;

   // Reference model state per channel.
   int m_l     [N];
   int m_d     [N];
   int m_n     [N];
   int m_start [N];
   int m_wait  [N];  // ticks left before the next level step
   int m_level [N];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic chk_ch(input string tag, input int k, input int exp);
      logic [W-1:0] got;
      got = bus.Vo[k*W +: W];
      check(tag, 32'(got), 32'(exp));
   endtask

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         m_l[k] = 0; m_d[k] = 0; m_n[k] = 0;
         m_start[k] = 0; m_wait[k] = 0; m_level[k] = 0;
      end
   endtask

   function automatic logic [N*W-1:0] model_vo();
      logic [N*W-1:0] v;
      v = '0;
      for (int k = 0; k < N; k++) begin
         v[k*W +: W] = W'(m_d[k] != 0 ? m_n[k] : m_level[k]);
      end
      return v;
   endfunction

   // One clock edge of the model. The tick acts on the state from before
   // the edge. After that, restart sets start and set loads the new
   // settings.
   task automatic model_edge(input logic [N-1:0] s, input logic li, input logic di,
                             input logic [W-1:0] ni, input logic [N-1:0] r, input logic q);
      for (int k = 0; k < N; k++) begin
         if (q) begin
            if (m_start[k] != 0) begin
               m_start[k] = 0;
               m_level[k] = MAXV;
               m_wait[k]  = m_n[k];
            end else if (m_wait[k] == 0) begin
               m_wait[k] = m_n[k];
               if (m_level[k] > 0) m_level[k] = m_level[k] - 1;
               else if (m_l[k] != 0) m_level[k] = MAXV;
            end else begin
               m_wait[k] = m_wait[k] - 1;
            end
         end
         if (r[k]) m_start[k] = 1;
         if (s[k]) begin
            m_l[k] = int'(li);
            m_d[k] = int'(di);
            m_n[k] = int'(ni);
         end
      end
   endtask

   task automatic check_model(input string tag);
      check(tag, 32'(bus.Vo), 32'(model_vo()));
   endtask

   // Drives one cycle of inputs, updates the model at the edge, then
   // compares #1 after the edge.
   task automatic cyc(input logic [N-1:0] s, input logic li, input logic di,
                      input logic [W-1:0] ni, input logic [N-1:0] r, input logic q);
      bus.set = s; bus.l = li; bus.d = di; bus.n = ni;
      bus.restart = r; bus.qframe = q;
      @(posedge m_clock);
      model_edge(s, li, di, ni, r, q);
      #1;
      bus.set = '0; bus.restart = '0; bus.qframe = 1'b0;
      check_model("model");
   endtask

   task automatic tick();
      cyc('0, 1'b0, 1'b0, '0, '0, 1'b1);
   endtask

   task automatic cyc5(input logic [3:0] s, input logic li, input logic di,
                       input logic [4:0] ni, input logic [3:0] r, input logic q);
      bus5.set = s; bus5.l = li; bus5.d = di; bus5.n = ni;
      bus5.restart = r; bus5.qframe = q;
      @(posedge m_clock);
      #1;
      bus5.set = '0; bus5.restart = '0; bus5.qframe = 1'b0;
   endtask

   initial begin
      logic [19:0] e5;
      int exp;

      p_reset = 1'b1;
      bus.set = '0; bus.l = 1'b0; bus.d = 1'b0; bus.n = '0;
      bus.restart = '0; bus.qframe = 1'b0;
      bus5.set = '0; bus5.l = 1'b0; bus5.d = 1'b0; bus5.n = '0;
      bus5.restart = '0; bus5.qframe = 1'b0;
      model_reset();
      #2;
      check("reset_vo", 32'(bus.Vo), 32'd0);
      #10 p_reset = 1'b0;

      // Constant mode on channel 0.
      cyc(3'b001, 1'b0, 1'b1, 4'd9, '0, 1'b0);
      chk_ch("const_ch0", 0, 9);
      chk_ch("const_ch1", 1, 0);
      chk_ch("const_ch2", 2, 0);
      tick();
      chk_ch("const_qframe", 0, 9);
      cyc('0, 1'b0, 1'b0, '0, 3'b001, 1'b0);
      tick();
      chk_ch("const_restart", 0, 9);

      // Asynchronous reset in the middle of a clock period.
      #3 p_reset = 1'b1;
      #1;
      model_reset();
      check("async_reset", 32'(bus.Vo), 32'd0);
      #2 p_reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc('0, 1'b0, 1'b0, '0, '0, 1'(i % 2));
         check("post_reset_zero", 32'(bus.Vo), 32'd0);
      end

      // Non-looping decay on channel 1, period 3.
      cyc(3'b010, 1'b0, 1'b0, 4'd2, '0, 1'b0);
      cyc('0, 1'b0, 1'b0, '0, 3'b010, 1'b0);
      for (int t = 1; t <= 56; t++) begin
         tick();
         exp = MAXV - (t - 1) / 3;
         if (exp < 0) exp = 0;
         chk_ch($sformatf("decay_t%0d", t), 1, exp);
         cyc('0, 1'b0, 1'b0, '0, '0, 1'b0);
      end

      // Looping decay on channel 2, period 1.
      cyc(3'b100, 1'b1, 1'b0, 4'd0, '0, 1'b0);
      cyc('0, 1'b0, 1'b0, '0, 3'b100, 1'b0);
      for (int t = 1; t <= 20; t++) begin
         tick();
         chk_ch($sformatf("loop_t%0d", t), 2, MAXV - ((t - 1) % 16));
      end

      // Restart on channel 0 in the same cycle as a tick, at level 7.
      cyc(3'b001, 1'b0, 1'b0, 4'd1, '0, 1'b0);
      cyc('0, 1'b0, 1'b0, '0, 3'b001, 1'b0);
      for (int t = 1; t <= 17; t++) tick();
      chk_ch("collide_pre", 0, 7);
      cyc('0, 1'b0, 1'b0, '0, 3'b001, 1'b1);
      chk_ch("collide_same", 0, 7);
      cyc('0, 1'b0, 1'b0, '0, '0, 1'b0);
      chk_ch("collide_idle", 0, 7);
      tick();
      chk_ch("collide_reload", 0, MAXV);

      // Rewrite the period on channel 1 while its divider counts down from 2.
      cyc(3'b010, 1'b1, 1'b0, 4'd2, 3'b010, 1'b0);
      tick();
      tick();
      cyc(3'b010, 1'b1, 1'b0, 4'd5, '0, 1'b0);
      for (int i = 1; i <= 14; i++) begin
         tick();
         exp = (i == 1) ? 15 : (i <= 7) ? 14 : (i <= 13) ? 13 : 12;
         chk_ch($sformatf("rewrite_i%0d", i), 1, exp);
      end

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         cyc(N'($urandom) & N'($urandom) & N'($urandom),
             1'($urandom), 1'($urandom_range(0, 3) == 0), W'($urandom_range(0, 3)),
             N'($urandom) & N'($urandom) & N'($urandom) & N'($urandom),
             1'($urandom));
      end

      // Parameter sweep: N=4, W=5.
      cyc5(4'b1000, 1'b1, 1'b0, 5'd0, 4'b0000, 1'b0);
      check("w5_set", 32'(bus5.Vo), 32'd0);
      cyc5(4'b0000, 1'b0, 1'b0, 5'd0, 4'b1000, 1'b0);
      check("w5_restart", 32'(bus5.Vo), 32'd0);
      cyc5(4'b0000, 1'b0, 1'b0, 5'd0, 4'b0000, 1'b1);
      e5 = 20'd31 << 15;
      check("w5_max", 32'(bus5.Vo), 32'(e5));
      cyc5(4'b0000, 1'b0, 1'b0, 5'd0, 4'b0000, 1'b1);
      e5 = 20'd30 << 15;
      check("w5_dec", 32'(bus5.Vo), 32'(e5));
      cyc5(4'b0001, 1'b0, 1'b1, 5'd21, 4'b0000, 1'b0);
      e5 = (20'd30 << 15) | 20'd21;
      check("w5_const_ch0", 32'(bus5.Vo), 32'(e5));
      for (int t = 0; t < 30; t++) cyc5(4'b0000, 1'b0, 1'b0, 5'd0, 4'b0000, 1'b1);
      e5 = 20'd21;
      check("w5_zero", 32'(bus5.Vo), 32'(e5));
      cyc5(4'b0000, 1'b0, 1'b0, 5'd0, 4'b0000, 1'b1);
      e5 = (20'd31 << 15) | 20'd21;
      check("w5_wrap", 32'(bus5.Vo), 32'(e5));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
